// File: rtl/wb_store_queue_if.sv
// Bus bundle for the write-back store queue: the WriteBack-side store port
// and the data-cache core-bus request/ack handshake.
// slave  : the view taken by wb_store_queue itself.
// master : the view taken by the environment (WriteBack stage + d-cache).
interface wb_store_queue_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int TAG_W  = 13
) ();
  // WriteBack store port
  logic              st_valid;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic              kill_in;
  logic              st_ready;
  logic              stall_out;
  // d-cache core bus
  logic              reqcyc;
  logic [ADDR_W-1:0] req;
  logic [DATA_W-1:0] reqdata;
  logic [TAG_W-1:0]  reqtag;
  logic              reqack;
  logic              writeack;
  logic              did_write_out;

  modport slave (
    input  st_valid, st_addr, st_data, kill_in, reqack, writeack,
    output st_ready, stall_out, reqcyc, req, reqdata, reqtag, did_write_out
  );

  modport master (
    output st_valid, st_addr, st_data, kill_in, reqack, writeack,
    input  st_ready, stall_out, reqcyc, req, reqdata, reqtag, did_write_out
  );
endinterface

// File: rtl/wb_store_queue.sv
// Write-back store queue. Committed stores are buffered in a DEPTH-entry FIFO
// and drained in order to the d-cache with the reqcyc/reqack/writeack
// handshake, so WriteBack only stalls when the queue is full.
// Optional store-to-load forwarding is enabled by defining WB_STORE_FWD_EN.
module wb_store_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int TAG_W  = 13,
  // {WRITE, MEMORY, DATA, 7'b0}: write op, memory unit, data cache
  parameter logic [TAG_W-1:0] WRITE_TAG = TAG_W'({2'b01, 2'b01, 2'b01, 7'b0})
) (
  input  logic                       clk,
  input  logic                       reset_n,
  wb_store_queue_if.slave            bus,
  output logic [$clog2(DEPTH):0]     count_out,
  output logic                       empty_out,
  input  logic [ADDR_W-1:0]          fwd_addr,
  output logic                       fwd_hit,
  output logic [DATA_W-1:0]          fwd_data
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RETIRE
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]  addr_mem_q [DEPTH];
  logic [ADDR_W-1:0]  addr_mem_d [DEPTH];
  logic [DATA_W-1:0]  data_mem_q [DEPTH];
  logic [DATA_W-1:0]  data_mem_d [DEPTH];

  logic [PTR_W-1:0]   count;
  logic [IDX_W-1:0]   head_idx;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;

  // Occupancy and handshake flags come from registered pointers only, so
  // st_ready never depends on a same-cycle pop.
  assign count    = wr_ptr_q - rd_ptr_q;
  assign head_idx = rd_ptr_q[IDX_W-1:0];
  assign full     = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                    (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign push     = bus.st_valid && !full && !bus.kill_in;
  assign pop      = (state_q == S_RETIRE);

  assign bus.st_ready  = !full;
  assign bus.stall_out = bus.st_valid && full;
  assign count_out     = count;
  assign empty_out     = empty;

  // Next pointers and next storage contents for push/pop.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    addr_mem_d = addr_mem_q;
    data_mem_d = data_mem_q;
    if (push) begin
      addr_mem_d[wr_ptr_q[IDX_W-1:0]] = bus.st_addr;
      data_mem_d[wr_ptr_q[IDX_W-1:0]] = bus.st_data;
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  // Control state: pointers and drain FSM, cleared by reset (this also
  // abandons any outstanding cache transaction).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      state_q  <= S_IDLE;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      state_q  <= state_d;
    end
  end

  // Entry storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    addr_mem_q <= addr_mem_d;
    data_mem_q <= data_mem_d;
  end

  // Drain FSM next state and bus outputs; the head entry is held until its
  // writeack, so req/reqdata stay stable for the whole request.
  always_comb begin
    state_d           = state_q;
    bus.reqcyc        = 1'b0;
    bus.req           = '0;
    bus.reqdata       = '0;
    bus.reqtag        = '0;
    bus.did_write_out = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) state_d = S_REQ;
      end
      S_REQ: begin
        bus.reqcyc  = 1'b1;
        bus.req     = addr_mem_q[head_idx];
        bus.reqdata = data_mem_q[head_idx];
        bus.reqtag  = WRITE_TAG;
        if (bus.reqack) state_d = bus.writeack ? S_RETIRE : S_WAIT;
      end
      S_WAIT: begin
        if (bus.writeack) state_d = S_RETIRE;
      end
      S_RETIRE: begin
        bus.did_write_out = 1'b1;
        // Entries remain after this pop if more than one was queued or a
        // new store is being accepted in the same cycle.
        state_d = ((count != PTR_W'(1)) || push) ? S_REQ : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef WB_STORE_FWD_EN
  logic [IDX_W-1:0] fwd_idx;

  // Scan from head to tail so the youngest matching store wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head_idx + IDX_W'(i);
      if ((PTR_W'(i) < count) && (addr_mem_q[fwd_idx] == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_mem_q[fwd_idx];
      end
    end
  end
`else
  logic unused_fwd_addr;

  assign unused_fwd_addr = ^fwd_addr;
  assign fwd_hit         = 1'b0;
  assign fwd_data        = '0;
`endif

endmodule

// File: tb/tb_wb_store_queue.sv
// Directed testbench for wb_store_queue (DEPTH=4, 64-bit address/data).
module tb_wb_store_queue;

  localparam int         DEPTH     = 4;
  localparam logic [12:0] WRITE_TAG = 13'h0A80;
`ifdef WB_STORE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  count_out;
  logic        empty_out;
  logic [63:0] fwd_addr;
  logic        fwd_hit;
  logic [63:0] fwd_data;

  int n_checks = 0;
  int n_errors = 0;
  int pulses   = 0;

  wb_store_queue_if #(.ADDR_W(64), .DATA_W(64), .TAG_W(13)) bus ();

  wb_store_queue #(.DEPTH(DEPTH), .ADDR_W(64), .DATA_W(64), .TAG_W(13)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .count_out (count_out),
    .empty_out (empty_out),
    .fwd_addr  (fwd_addr),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; sample 1ns after the edge and count retire pulses.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.did_write_out === 1'b1) pulses++;
  endtask

  task automatic push(input logic [63:0] a, input logic [63:0] d);
    bus.st_valid = 1'b1;
    bus.st_addr  = a;
    bus.st_data  = d;
    tick();
    bus.st_valid = 1'b0;
  endtask

  // Act as the d-cache for one request. wdelay=0 gives reqack+writeack in
  // the same cycle; otherwise writeack arrives wdelay cycles after reqack.
  task automatic serve(input int wdelay, output logic [63:0] a,
                       output logic [63:0] d, output int waited);
    waited = 0;
    a = '0;
    d = '0;
    while (bus.reqcyc !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    if (bus.reqcyc !== 1'b1) begin
      chk("reqcyc_timeout", 64'(bus.reqcyc), 64'd1);
      return;
    end
    a = bus.req;
    d = bus.reqdata;
    chk("reqtag", 64'(bus.reqtag), 64'(WRITE_TAG));
    bus.reqack   = 1'b1;
    bus.writeack = (wdelay == 0);
    tick();
    bus.reqack   = 1'b0;
    bus.writeack = 1'b0;
    if (wdelay > 0) begin
      chk("wait_reqcyc_low", 64'(bus.reqcyc), 64'd0);
      chk("wait_no_pulse", 64'(bus.did_write_out), 64'd0);
      repeat (wdelay - 1) tick();
      bus.writeack = 1'b1;
      tick();
      bus.writeack = 1'b0;
    end
    chk("retire_pulse", 64'(bus.did_write_out), 64'd1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] a, d;
    int          w;
    int          n;
    int          k;

    reset_n      = 1'b0;
    bus.st_valid = 1'b0;
    bus.st_addr  = '0;
    bus.st_data  = '0;
    bus.kill_in  = 1'b0;
    bus.reqack   = 1'b0;
    bus.writeack = 1'b0;
    fwd_addr     = '0;

    // Reset state
    tick();
    tick();
    chk("rst_reqcyc", 64'(bus.reqcyc), 64'd0);
    chk("rst_count", 64'(count_out), 64'd0);
    chk("rst_empty", 64'(empty_out), 64'd1);
    chk("rst_ready", 64'(bus.st_ready), 64'd1);
    chk("rst_req", bus.req, 64'd0);
    chk("rst_reqdata", bus.reqdata, 64'd0);
    chk("rst_reqtag", 64'(bus.reqtag), 64'd0);
    chk("rst_did_write", 64'(bus.did_write_out), 64'd0);
    chk("rst_fwd_hit", 64'(fwd_hit), 64'd0);
    chk("rst_fwd_data", fwd_data, 64'd0);
    reset_n = 1'b1;
    tick();

    // Single store with reqack two cycles after the push, writeack 3 later
    push(64'h1000, 64'hDEAD);
    chk("single_count", 64'(count_out), 64'd1);
    chk("single_reqcyc_early", 64'(bus.reqcyc), 64'd0);
    serve(3, a, d, w);
    chk("single_latency", 64'(w), 64'd1);
    chk("single_req", a, 64'h1000);
    chk("single_reqdata", d, 64'hDEAD);
    chk("single_empty", 64'(empty_out), 64'd1);
    chk("single_count_after", 64'(count_out), 64'd0);
    chk("single_pulses", 64'(pulses), 64'd1);

    // Fill: five back-to-back offers with reqack held low
    for (int i = 0; i < 5; i++) begin
      bus.st_valid = 1'b1;
      bus.st_addr  = 64'h2000 + 64'(8 * i);
      bus.st_data  = 64'h100 + 64'(i);
      #1;
      chk("fill_ready", 64'(bus.st_ready), (i == 4) ? 64'd0 : 64'd1);
      chk("fill_stall", 64'(bus.stall_out), (i == 4) ? 64'd1 : 64'd0);
      tick();
    end
    bus.st_valid = 1'b0;
    chk("fill_count", 64'(count_out), 64'd4);
    chk("fill_reqcyc", 64'(bus.reqcyc), 64'd1);
    chk("fill_req_head", bus.req, 64'h2000);
    tick();
    chk("fill_req_stable", bus.req, 64'h2000);
    chk("fill_reqdata_stable", bus.reqdata, 64'h100);
    for (int i = 0; i < 4; i++) begin
      serve(0, a, d, w);
      chk("fill_drain_addr", a, 64'h2000 + 64'(8 * i));
      chk("fill_drain_data", d, 64'h100 + 64'(i));
      chk("fill_drain_b2b", 64'(w), 64'd0);
    end
    chk("fill_empty", 64'(empty_out), 64'd1);
    chk("fill_pulses", 64'(pulses), 64'd5);

    // Kill: squashed store leaves no trace, next store proceeds
    bus.st_valid = 1'b1;
    bus.kill_in  = 1'b1;
    bus.st_addr  = 64'h3000;
    bus.st_data  = 64'h55;
    #1;
    chk("kill_stall", 64'(bus.stall_out), 64'd0);
    tick();
    bus.st_valid = 1'b0;
    bus.kill_in  = 1'b0;
    chk("kill_count", 64'(count_out), 64'd0);
    tick();
    chk("kill_no_reqcyc", 64'(bus.reqcyc), 64'd0);
    tick();
    chk("kill_no_reqcyc2", 64'(bus.reqcyc), 64'd0);
    push(64'h3008, 64'h77);
    chk("kill_next_count", 64'(count_out), 64'd1);
    serve(1, a, d, w);
    chk("kill_next_addr", a, 64'h3008);
    chk("kill_next_data", d, 64'h77);
    chk("kill_next_latency", 64'(w), 64'd1);

    // Ten stores with reqack+writeack coinciding; pointers wrap
    k = 0;
    for (int b = 0; b < 4; b++) begin
      n = (b == 3) ? 1 : 3;
      for (int j = 0; j < n; j++) push(64'h4000 + 64'(k + j), 64'hA000 + 64'(k + j));
      chk("wrap_count", 64'(count_out), 64'(n));
      for (int j = 0; j < n; j++) begin
        serve(0, a, d, w);
        chk("wrap_addr", a, 64'h4000 + 64'(k + j));
        chk("wrap_data", d, 64'hA000 + 64'(k + j));
        if (j > 0) chk("wrap_b2b", 64'(w), 64'd0);
      end
      k += n;
    end
    chk("wrap_empty", 64'(empty_out), 64'd1);
    chk("wrap_pulses", 64'(pulses), 64'd16);

    // Reset in the middle of WAIT; a late writeack is ignored
    push(64'h5000, 64'h99);
    tick();
    chk("rstw_reqcyc", 64'(bus.reqcyc), 64'd1);
    bus.reqack = 1'b1;
    tick();
    bus.reqack = 1'b0;
    chk("rstw_in_wait", 64'(bus.reqcyc), 64'd0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("rstw_reqcyc_after", 64'(bus.reqcyc), 64'd0);
    chk("rstw_count", 64'(count_out), 64'd0);
    chk("rstw_empty", 64'(empty_out), 64'd1);
    bus.writeack = 1'b1;
    tick();
    bus.writeack = 1'b0;
    chk("rstw_late_ack_pulse", 64'(bus.did_write_out), 64'd0);
    chk("rstw_late_ack_count", 64'(count_out), 64'd0);
    tick();
    chk("rstw_idle", 64'(bus.reqcyc), 64'd0);
    chk("rstw_pulses", 64'(pulses), 64'd16);

    // Forwarding: youngest match wins, entries stop matching once retired
    push(64'h40, 64'd1);
    push(64'h40, 64'd2);
    fwd_addr = 64'h40;
    #1;
    chk("fwd_hit_two", 64'(fwd_hit), FWD ? 64'd1 : 64'd0);
    chk("fwd_data_two", fwd_data, FWD ? 64'd2 : 64'd0);
    fwd_addr = 64'h48;
    #1;
    chk("fwd_miss", 64'(fwd_hit), 64'd0);
    fwd_addr = 64'h40;
    serve(0, a, d, w);
    chk("fwd_drain1", d, 64'd1);
    chk("fwd_hit_one", 64'(fwd_hit), FWD ? 64'd1 : 64'd0);
    chk("fwd_data_one", fwd_data, FWD ? 64'd2 : 64'd0);
    serve(0, a, d, w);
    chk("fwd_drain2", d, 64'd2);
    chk("fwd_hit_none", 64'(fwd_hit), 64'd0);
    chk("fwd_data_none", fwd_data, 64'd0);
    chk("total_pulses", 64'(pulses), 64'd18);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
